wallace_mult_pipe: RTL and testbench

- Parametrised, fully pipelined Wallace-tree multiplier with a valid/ready handshake and a per-operand signed/unsigned mode.
- Generalises the fixed 16x16 unsigned multiplier to any power-of-two WIDTH.
- Partial products are reduced by log2(WIDTH)-1 registered levels of 4:2 compressors, then summed by a registered Kogge-Stone final adder.
- Sits between operand producers (DSP datapath, MAC accumulator) and a consumer that may stall.

---
 rtl/wallace_pkg.sv | 24 ++
 rtl/comp4_2.sv | 17 +
 rtl/csa42_level.sv | 35 +++
 rtl/full_a.sv | 11 +
 rtl/half_a.sv | 10 +
 rtl/kogge_stone_adder.sv | 32 +++
 rtl/wallace_mult_pipe.sv | 104 ++++++++++
 tb/tb_wallace_mult_pipe.sv | 229 ++++++++++++++++++++++
 8 files changed

// File: rtl/wallace_pkg.sv
// Shared helpers for the pipelined Wallace multiplier: derived depths and the
// Baugh-Wooley correction constant used for two's-complement operands.
package wallace_pkg;

    localparam int MAX_W2 = 128;

    function automatic int levels_f(input int width);
        return $clog2(width) - 1;
    endfunction

    function automatic int latency_f(input int width);
        return levels_f(width) + 2;
    endfunction

    // Ones at columns width and 2*width-1; callers truncate to 2*width bits.
    function automatic logic [MAX_W2-1:0] bw_const_f(input int width);
        logic [MAX_W2-1:0] c;
        c = '0;
        c[width] = 1'b1;
        c[2*width-1] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/comp4_2.sv
// 4:2 compressor from two full adders; cout depends only on x1..x3, so
// chaining cout into the next column's cin never ripples.
module comp4_2 (
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic cin,
    output logic sum,
    output logic carry,
    output logic cout
);
    logic s1;

    full_a u_fa_hi (.a(x1), .b(x2), .ci(x3),  .s(s1),  .co(cout));
    full_a u_fa_lo (.a(s1), .b(x4), .ci(cin), .s(sum), .co(carry));
endmodule

// File: rtl/csa42_level.sv
// One combinational reduction level: each group of four rows becomes a sum
// row and a carry row; all arithmetic is modulo 2^W2.
module csa42_level #(
    parameter int ROWS_IN = 16,
    parameter int W2      = 32
) (
    input  logic [ROWS_IN*W2-1:0]     rows_in,
    output logic [(ROWS_IN/2)*W2-1:0] rows_out
);
    for (genvar g = 0; g < ROWS_IN/4; g++) begin : g_grp
        logic [W2-1:0] x1, x2, x3, x4, s, cy, co;
        logic          s1_lsb;
        logic          unused_msb;

        assign x1 = rows_in[(4*g+0)*W2 +: W2];
        assign x2 = rows_in[(4*g+1)*W2 +: W2];
        assign x3 = rows_in[(4*g+2)*W2 +: W2];
        assign x4 = rows_in[(4*g+3)*W2 +: W2];

        // Column 0 has no incoming cin, so a half adder finishes it.
        full_a u_fa0 (.a(x1[0]), .b(x2[0]), .ci(x3[0]), .s(s1_lsb), .co(co[0]));
        half_a u_ha0 (.a(s1_lsb), .b(x4[0]), .s(s[0]), .c(cy[0]));

        for (genvar c = 1; c < W2; c++) begin : g_col
            comp4_2 u_c42 (
                .x1(x1[c]), .x2(x2[c]), .x3(x3[c]), .x4(x4[c]), .cin(co[c-1]),
                .sum(s[c]), .carry(cy[c]), .cout(co[c])
            );
        end

        assign rows_out[(2*g)*W2 +: W2]   = s;
        assign rows_out[(2*g+1)*W2 +: W2] = {cy[W2-2:0], 1'b0};
        assign unused_msb = cy[W2-1] ^ co[W2-1];
    end
endmodule

// File: rtl/full_a.sv
// Full adder leaf cell; combinational, no flow control.
module full_a (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/half_a.sv
// Half adder leaf cell; combinational, no flow control.
module half_a (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/kogge_stone_adder.sv
// Parametrised Kogge-Stone prefix adder; combinational, no flow control.
module kogge_stone_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int LOG = $clog2(W);

    logic [W-1:0] g [0:LOG];
    logic [W-1:0] pr [0:LOG];

    always_comb begin
        g[0]    = a & b;
        pr[0]   = a ^ b;
        g[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        for (int l = 0; l < LOG; l++) begin
            g[l+1]  = g[l];
            pr[l+1] = pr[l];
            for (int i = (1 << l); i < W; i++) begin
                g[l+1][i]  = g[l][i] | (pr[l][i] & g[l][i-(1<<l)]);
                pr[l+1][i] = pr[l][i] & pr[l][i-(1<<l)];
            end
        end
    end

    assign sum  = pr[0] ^ {g[LOG][W-2:0], cin};
    assign cout = g[LOG][W-1];
endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined Baugh-Wooley/Wallace multiplier, LATENCY cycles per result.
// Global stall: while out_valid && !out_ready every stage holds and in_ready is low.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LEVELS  = levels_f(WIDTH),
    parameter int LATENCY = latency_f(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);
    localparam int                W2       = 2 * WIDTH;
    localparam int                NROWS_Q  = WIDTH - 2;
    localparam logic [WIDTH-1:0]  MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [W2-1:0]     BW_CONST = W2'(bw_const_f(WIDTH));

    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("wallace_mult_pipe: WIDTH must be a power of two in 8..64");
    end
    if (LEVELS != levels_f(WIDTH) || LATENCY != latency_f(WIDTH)) begin : g_bad_derived
        $error("wallace_mult_pipe: LEVELS and LATENCY are derived from WIDTH");
    end

    logic                    stall;
    logic [WIDTH-1:0]        a_q, b_q;
    logic                    sm_q;
    logic [LEVELS:0]         v_q;
    logic [WIDTH*W2-1:0]     pp;
    logic [NROWS_Q*W2-1:0]   lvl_d, lvl_q;
    logic [W2-1:0]           sum;
    logic                    unused_cout;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Partial products: flip bits that pair exactly one operand MSB in signed mode.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        localparam logic [WIDTH-1:0] INV = (i == WIDTH-1) ? ~MSB_ONLY : MSB_ONLY;
        logic [WIDTH-1:0] bits;

        assign bits = ({WIDTH{b_q[i]}} & a_q) ^ ({WIDTH{sm_q}} & INV);
        if (i == 0) begin : g_row0
            assign pp[0 +: W2] = {{WIDTH{1'b0}}, bits} | ({W2{sm_q}} & BW_CONST);
        end else begin : g_rown
            assign pp[i*W2 +: W2] = {{WIDTH{1'b0}}, bits} << i;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int RIN = WIDTH >> (k - 1);
        logic [RIN*W2-1:0] rin;

        if (k == 1) begin : g_src_pp
            assign rin = pp;
        end else begin : g_src_lvl
            assign rin = lvl_q[(WIDTH - 2*RIN)*W2 +: RIN*W2];
        end

        csa42_level #(.ROWS_IN(RIN), .W2(W2)) u_level (
            .rows_in  (rin),
            .rows_out (lvl_d[(WIDTH - RIN)*W2 +: (RIN/2)*W2])
        );
    end

    kogge_stone_adder #(.W(W2)) u_final (
        .a    (lvl_q[(WIDTH-4)*W2 +: W2]),
        .b    (lvl_q[(WIDTH-3)*W2 +: W2]),
        .cin  (1'b0),
        .sum  (sum),
        .cout (unused_cout)
    );

    always_ff @(posedge clk) begin
        if (!stall) begin
            a_q   <= a;
            b_q   <= b;
            sm_q  <= signed_mode;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            p         <= '0;
        end else if (!stall) begin
            v_q       <= {v_q[LEVELS-1:0], in_valid};
            out_valid <= v_q[LEVELS];
            if (v_q[LEVELS]) begin
                p <= sum;
            end
        end
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench: drivers push expected products, a negedge monitor pops and compares.
module tb_wallace_mult_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [15:0] a, b;
    logic [31:0] p;

    logic        v8_in_valid, v8_in_ready, v8_sm, v8_out_valid;
    logic [7:0]  v8_a, v8_b;
    logic [15:0] v8_p;
    logic        v32_in_valid, v32_in_ready, v32_sm, v32_out_valid;
    logic [31:0] v32_a, v32_b;
    logic [63:0] v32_p;

    wallace_mult_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );
    wallace_mult_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready), .a(v8_a), .b(v8_b),
        .signed_mode(v8_sm), .out_valid(v8_out_valid), .out_ready(1'b1), .p(v8_p)
    );
    wallace_mult_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32_in_valid), .in_ready(v32_in_ready), .a(v32_a), .b(v32_b),
        .signed_mode(v32_sm), .out_valid(v32_out_valid), .out_ready(1'b1), .p(v32_p)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] exp_q[$];
    int          tag_q[$];
    bit          lat_q[$];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [31:0] p;
    } vec_t;

    vec_t vecs [12] = '{
        '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001},
        '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000},
        '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001},
        '{16'h8000, 16'h8000, 1'b1, 32'h40000000},
        '{16'h8000, 16'h7FFF, 1'b0, 32'h3FFF8000},
        '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF},
        '{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF},
        '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001},
        '{16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA},
        '{16'h0000, 16'h1234, 1'b1, 32'h00000000},
        '{16'h0005, 16'hFFFD, 1'b1, 32'hFFFFFFF1},
        '{16'h1234, 16'h5678, 1'b0, 32'h06260060}
    };

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
        longint xx, yy;
        xx = s ? longint'($signed(x)) : longint'(x);
        yy = s ? longint'($signed(y)) : longint'(y);
        return 32'(xx * yy);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious out_valid", out_valid, 1'b0);
            end else if (out_ready) begin
                check("product", p, exp_q[0]);
                if (lat_q[0]) check("latency", cyc - tag_q[0], 5);
                void'(exp_q.pop_front());
                void'(tag_q.pop_front());
                void'(lat_q.pop_front());
            end else begin
                check("stall in_ready", in_ready, 1'b0);
                check("stall p hold", p, exp_q[0]);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic [31:0] want, input bit lat);
        int guard = 0;
        in_valid = 1'b1; a = x; b = y; signed_mode = s;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("input accepted", in_ready, 1'b1);
        exp_q.push_back(want);
        tag_q.push_back(cyc);
        lat_q.push_back(lat);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic sweep_op(input int w, input logic [31:0] x, input logic [31:0] y,
                            input logic s, input logic [63:0] want);
        int t;
        int guard = 0;
        if (w == 8) begin
            v8_a = x[7:0]; v8_b = y[7:0]; v8_sm = s; v8_in_valid = 1'b1;
        end else begin
            v32_a = x; v32_b = y; v32_sm = s; v32_in_valid = 1'b1;
        end
        @(negedge clk);
        t = cyc;
        @(posedge clk); #1;
        v8_in_valid = 1'b0;
        v32_in_valid = 1'b0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(w == 8 ? v8_out_valid : v32_out_valid) && guard < 20);
        check($sformatf("w%0d out_valid", w), (w == 8) ? v8_out_valid : v32_out_valid, 1'b1);
        check($sformatf("w%0d latency", w), cyc - t, (w == 8) ? 4 : 6);
        check($sformatf("w%0d product", w), (w == 8) ? {48'b0, v8_p} : v32_p, want);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; signed_mode = 1'b0;
        v8_in_valid = 1'b0; v8_a = '0; v8_b = '0; v8_sm = 1'b0;
        v32_in_valid = 1'b0; v32_a = '0; v32_b = '0; v32_sm = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", out_valid, 1'b0);
        check("reset p", p, 32'h0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset w8 out_valid", v8_out_valid, 1'b0);
        check("reset w32 out_valid", v32_out_valid, 1'b0);
        @(posedge clk); #1;

        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, 1'b1);
        drain("directed drain");

        for (int i = 0; i < 300; i++) begin
            logic [15:0] x, y;
            logic s;
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'($urandom_range(1));
            if (i >= 200 && $urandom_range(3) == 0) begin
                @(posedge clk); #1;
            end
            send(x, y, s, ref_mul(x, y, s), 1'b1);
        end
        drain("stream drain");

        send(16'd3, 16'd5, 1'b0, 32'd15, 1'b0);
        send(16'd7, 16'd9, 1'b0, 32'd63, 1'b0);
        send(16'h1234, 16'h0010, 1'b0, 32'h12340, 1'b0);
        out_ready = 1'b0;
        begin
            int guard = 0;
            while (!out_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        check("bp first valid", out_valid, 1'b1);
        repeat (6) @(negedge clk);
        check("bp still queued", exp_q.size(), 3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("bp drain");

        send(16'd3, 16'd4, 1'b0, 32'd12, 1'b1);
        send(16'd5, 16'd6, 1'b0, 32'd30, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        tag_q.delete();
        lat_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst p", p, 32'h0);
        check("midrst in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        send(16'd2, 16'd3, 1'b0, 32'd6, 1'b1);
        drain("post reset drain");
        repeat (12) @(posedge clk);
        #1;

        sweep_op(8, 32'h80, 32'h80, 1'b1, 64'h4000);
        sweep_op(8, 32'hFF, 32'hFF, 1'b0, 64'hFE01);
        sweep_op(8, 32'h7F, 32'h80, 1'b1, 64'hC080);
        sweep_op(32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
        sweep_op(32, 32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000);
        sweep_op(32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
